// File: rtl/aidan_mcnay_sipo_stream.sv
// Serial-to-parallel deserializer with valid/ready on both sides, selectable bit
// order, synchronous flush and a one-word output buffer that lets capture continue.
module aidan_mcnay_sipo_stream #(
    parameter int nbits     = 16,
    parameter bit msb_first = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_val,
    output logic                     in_rdy,
    input  logic                     data_in,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [nbits-1:0]         data_out,
    output logic [$clog2(nbits)-1:0] bit_count
);
    localparam int CW = $clog2(nbits);

    logic [nbits-1:0] r_sr;
    logic [nbits-1:0] r_obuf;
    logic [CW-1:0]    r_cnt;
    logic             r_full;

    logic [nbits-1:0] w_shift;
    logic             w_last;
    logic             w_acc;
    logic             w_cons;

    assign w_shift = msb_first ? {r_sr[nbits-2:0], data_in} : {data_in, r_sr[nbits-1:1]};
    assign w_last  = (r_cnt == CW'(nbits - 1));
    // Only the closing bit of a frame can stall, and only while the buffer is still owned.
    assign in_rdy  = !(r_full && !out_rdy && w_last);
    assign w_acc   = in_val && in_rdy && !flush;
    assign w_cons  = r_full && out_rdy && !flush;

    assign data_out  = r_obuf;
    assign out_val   = r_full;
    assign bit_count = r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_obuf <= '0;
            r_full <= 1'b0;
        end else if (flush) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else begin
            if (w_acc) begin
                if (w_last) begin
                    r_obuf <= w_shift;
                    r_sr   <= '0;
                    r_cnt  <= '0;
                end else begin
                    r_sr   <= w_shift;
                    r_cnt  <= r_cnt + CW'(1);
                end
            end
            // A completing frame keeps the buffer full even if the old word leaves this edge.
            if (w_acc && w_last)
                r_full <= 1'b1;
            else if (w_cons)
                r_full <= 1'b0;
        end
    end
endmodule

// File: doc/aidan_mcnay_sipo_stream.md
# aidan_mcnay_sipo_stream

Parametrised serial-to-parallel deserializer with valid/ready handshakes on both sides. Successor to the plain shift-register SIPO:
- adds frame counting, a selectable bit order, a synchronous flush, and a one-word output buffer, so serial capture continues while the parallel consumer stalls.
- sits between a bit-serial source (e.g. an input pin sampler) and word-wide datapath logic such as the prime-detection core.

## Interface
- `nbits`, default 16: word width and bits per frame; legal range 2..32.
- `msb_first`, default 1: 1 = first received bit lands in `data_out[nbits-1]`; 0 = first received bit lands in `data_out[0]`.

- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous abort; discards the partial frame and the buffered word.
- `in_val` in 1: serial bit valid.
- `in_rdy` out 1: serial bit accepted when `in_val && in_rdy` at a rising edge.
- `data_in` in 1: serial data bit.
- `out_val` out 1: `data_out` holds a complete word.
- `out_rdy` in 1: consumer takes the word when `out_val && out_rdy` at a rising edge.
- `data_out` out nbits: buffered parallel word.
- `bit_count` out clog2(nbits): number of bits accepted into the current partial frame.

## Operation
- **Internal state:** shift register `sr` (nbits), counter `cnt` (clog2(nbits) bits), output register `obuf` (nbits), flag `full`.
- **Outputs:** `data_out` = `obuf`; `out_val` = `full`; `bit_count` = `cnt`.
- **Shift rule:**
  - `msb_first`=1: `sr <= {sr[nbits-2:0], data_in}`.
  - `msb_first`=0: `sr <= {data_in, sr[nbits-1:1]}`.
- **Accepted bit, `cnt < nbits-1`:** shift; `cnt` increments.
- **Accepted bit, `cnt == nbits-1` (last bit):**
  - `obuf` loads the shifted value, i.e. the complete word including this bit.
  - `full` is set; `cnt` wraps to 0; `sr` is cleared to 0.
- **Consume:** `out_val && out_rdy` clears `full` unless a last bit is accepted the same edge. In that case `full` stays 1 and `obuf` takes the new word (zero-bubble).
- **`in_rdy`** = `!(full && !out_rdy && cnt == nbits-1)`.
  - Only the last bit of a frame is ever blocked.
  - Bits 0..nbits-2 of the next frame are accepted while the buffered word waits.
- **`flush`:** highest priority below reset.
  - Next edge: `sr`=0, `cnt`=0, `full`=0; `obuf` is held.
  - `in_val` and `out_rdy` are ignored that edge; no handshake completes.
- **Reset:** asynchronous. `sr`=0, `cnt`=0, `obuf`=0, `full`=0. Outputs therefore read `out_val`=0, `data_out`=0, `bit_count`=0, `in_rdy`=1.
  - Reset mid-frame or with a buffered word loses both; there is no partial output.
- `data_out` is stable whenever `out_val`=1 and no new word completes. It holds the last word after consumption.
- `in_rdy` depends combinationally on `out_rdy`. There is no combinational path from `in_val` or `data_in` to any output.

## Timing
- **Latency:** the last bit is accepted at edge k; `out_val`=1 and `data_out` are valid in the cycle after edge k.
- **Throughput:** one bit per cycle sustained. A word completes every nbits cycles with `out_rdy` tied high.
- **Backpressure:** with `out_rdy`=0, the source can deliver nbits-1 bits of the next frame. `in_rdy` drops in the cycle where `cnt == nbits-1` and `full`=1. It rises in the same cycle that `out_rdy` goes high.
- **Simultaneous last bit and consume:** both complete on one edge. `out_val` stays 1 and `data_out` updates to the new word.
- **Flush together with a last bit or consume:** flush wins. The word is not delivered and the frame is discarded.
- `in_val`=0 gaps of any length do not disturb `cnt` or `sr`.

## Test plan
- **Back-to-back MSB-first:** `nbits`=16, `msb_first`=1, `out_rdy`=1. Send 0xA5C3 MSB-first, back to back → `out_val` pulses 1 cycle after bit 16, `data_out`=16'hA5C3, `bit_count` sequence 0..15 then 0.
- **LSB-first with gaps:** `nbits`=8, `msb_first`=0. Send 0x96 LSB-first with random `in_val` gaps → `data_out`=8'h96, `in_rdy` always 1.
- **Backpressure:** `nbits`=16, `out_rdy`=0. Send 0x1234 then 0xFFFF.
  - `out_val`=1 with 0x1234.
  - `in_rdy`=0 once 15 bits of 0xFFFF are in.
  - Raise `out_rdy` for 1 cycle → 0x1234 consumed on the same edge the 16th bit is accepted; `data_out`=0xFFFF, `out_val` stays 1.
- **Flush mid-frame:** send 5 bits, assert `flush` 1 cycle → `bit_count`=0. Then send 0x0F0F → `data_out`=16'h0F0F, none of the 5 stale bits appear.
- **Async reset:** assert `reset` asynchronously mid-frame with `out_val`=1 → `out_val`, `data_out` and `bit_count` read 0 before the next clock edge. After release, a full 0xBEEF frame is received correctly.
- **Streaming:** `out_rdy`=1 throughout, stream 4 words (0x0001, 0x8000, 0xFFFF, 0x0000) continuously → each word is delivered exactly once, 16 cycles apart, with `in_rdy` constantly 1.
